// File: rtl/axi4_slave_ram.sv
// AXI4 burst slave backed by a byte-lane-writable RAM; independent read and write channel FSMs.
// Latency: AW hs -> wready next cycle, last W -> bvalid next cycle, AR hs -> first rvalid next cycle.
// Backpressure: bvalid/rvalid and their payloads hold until bready/rready; one burst per channel in flight.
module axi4_slave_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic               aclk,
    input  logic               areset_n,
    input  logic [3:0]         awid,
    input  logic [31:0]        awaddr,
    input  logic [7:0]         awlen,
    input  logic [2:0]         awsize,
    input  logic [1:0]         awburst,
    input  logic               awvalid,
    output logic               awready,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wstrb,
    input  logic               wlast,
    input  logic               wvalid,
    output logic               wready,
    output logic [3:0]         bid,
    output logic [1:0]         bresp,
    output logic               bvalid,
    input  logic               bready,
    input  logic [3:0]         arid,
    input  logic [31:0]        araddr,
    input  logic [7:0]         arlen,
    input  logic [2:0]         arsize,
    input  logic [1:0]         arburst,
    input  logic               arvalid,
    output logic               arready,
    output logic [3:0]         rid,
    output logic [WIDTH-1:0]   rdata,
    output logic [1:0]         rresp,
    output logic               rlast,
    output logic               rvalid,
    input  logic               rready
);

    localparam int BW   = WIDTH / 8;
    localparam int OFFW = $clog2(BW);
    localparam int IDXW = $clog2(DEPTH);
    localparam logic [2:0] SIZE_OK = 3'(OFFW);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    // Burst falls outside the array: address bits above the RAM, or an INCR run past the top word.
    function automatic logic is_decerr(input logic [31:0] addr, input logic [7:0] len,
                                       input logic [1:0] burst);
        logic [IDXW+8:0] last_word;
        last_word = (IDXW+9)'(addr[OFFW +: IDXW]) +
                    ((burst == BURST_INCR) ? (IDXW+9)'(len) : '0);
        return (|(addr >> (OFFW + IDXW))) || (last_word >= (IDXW+9)'(DEPTH));
    endfunction

    // Only full-width beats and FIXED/INCR bursts are supported.
    function automatic logic is_slverr(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_OK) || burst[1];
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    // ---------------- write channel ----------------
    logic [1:0]      w_state_q, w_state_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            bvalid_q, bvalid_d;
    logic [3:0]      bid_q, bid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic [IDXW-1:0] widx_q, widx_d;
    logic [7:0]      wlen_q, wlen_d;
    logic [7:0]      wcnt_q, wcnt_d;
    logic            wfixed_q, wfixed_d;
    logic            wdec_q, wdec_d;
    logic            wslv_q, wslv_d;
    logic            wlast_err_q, wlast_err_d;
    logic            aw_hs, w_hs, b_hs, w_final, mem_we;

    assign aw_hs   = awvalid && awready_q;
    assign w_hs    = wvalid && wready_q;
    assign b_hs    = bvalid_q && bready;
    assign w_final = (wcnt_q == wlen_q);
    // A wlast mismatch still commits; only decode/size/burst errors suppress the write.
    assign mem_we  = w_hs && !wdec_q && !wslv_q;

    // Write FSM next state: beats are counted against awlen, wlast is only checked.
    always_comb begin
        w_state_d   = w_state_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        widx_d      = widx_q;
        wlen_d      = wlen_q;
        wcnt_d      = wcnt_q;
        wfixed_d    = wfixed_q;
        wdec_d      = wdec_q;
        wslv_d      = wslv_q;
        wlast_err_d = wlast_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_state_d   = W_DATA;
                    bid_d       = awid;
                    widx_d      = awaddr[OFFW +: IDXW];
                    wlen_d      = awlen;
                    wcnt_d      = 8'd0;
                    wfixed_d    = (awburst == BURST_FIXED);
                    wdec_d      = is_decerr(awaddr, awlen, awburst);
                    wslv_d      = is_slverr(awsize, awburst);
                    wlast_err_d = 1'b0;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    if (w_final) begin
                        w_state_d = W_RESP;
                        if (wdec_q)
                            bresp_d = RESP_DECERR;
                        else if (wslv_q || wlast_err_q || !wlast)
                            bresp_d = RESP_SLVERR;
                        else
                            bresp_d = RESP_OKAY;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                        if (!wfixed_q)
                            widx_d = widx_q + IDXW'(1);
                        if (wlast)
                            wlast_err_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (b_hs)
                    w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Write channel registers; handshake outputs are registered so they are low during reset.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state_q   <= W_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= '0;
            widx_q      <= '0;
            wlen_q      <= '0;
            wcnt_q      <= '0;
            wfixed_q    <= 1'b0;
            wdec_q      <= 1'b0;
            wslv_q      <= 1'b0;
            wlast_err_q <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            widx_q      <= widx_d;
            wlen_q      <= wlen_d;
            wcnt_q      <= wcnt_d;
            wfixed_q    <= wfixed_d;
            wdec_q      <= wdec_d;
            wslv_q      <= wslv_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    // Byte-lane write port; contents are intentionally not reset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < BW; b++) begin
                if (wstrb[b])
                    mem[widx_q][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    logic            r_state_q, r_state_d;
    logic            arready_q, arready_d;
    logic            rvalid_q, rvalid_d;
    logic [3:0]      rid_q, rid_d;
    logic [1:0]      rresp_q, rresp_d;
    logic            rlast_q, rlast_d;
    logic [WIDTH-1:0] rdata_q;
    logic [IDXW-1:0] ridx_q, ridx_d;
    logic [7:0]      rlen_q, rlen_d;
    logic [7:0]      rcnt_q, rcnt_d;
    logic            rfixed_q, rfixed_d;
    logic            ar_hs, r_hs, rd_load, rd_zero;
    logic [IDXW-1:0] rd_idx, r_next_idx;
    logic [1:0]      ar_resp;

    assign ar_hs      = arvalid && arready_q;
    assign r_hs       = rvalid_q && rready;
    assign r_next_idx = rfixed_q ? ridx_q : ridx_q + IDXW'(1);
    assign ar_resp    = is_decerr(araddr, arlen, arburst) ? RESP_DECERR :
                        is_slverr(arsize, arburst)        ? RESP_SLVERR : RESP_OKAY;

    // Read FSM next state: each beat's data is fetched on the edge that exposes it, so a
    // same-edge write to that word is not yet visible.
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rfixed_d  = rfixed_q;
        rd_load   = 1'b0;
        rd_zero   = 1'b0;
        rd_idx    = ridx_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rid_d     = arid;
                    rresp_d   = ar_resp;
                    rlast_d   = (arlen == 8'd0);
                    ridx_d    = araddr[OFFW +: IDXW];
                    rlen_d    = arlen;
                    rcnt_d    = 8'd0;
                    rfixed_d  = (arburst == BURST_FIXED);
                    rd_load   = 1'b1;
                    rd_zero   = (ar_resp != RESP_OKAY);
                    rd_idx    = araddr[OFFW +: IDXW];
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rlast_d   = 1'b0;
                    end else begin
                        rcnt_d  = rcnt_q + 8'd1;
                        ridx_d  = r_next_idx;
                        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                        rd_load = 1'b1;
                        rd_zero = (rresp_q != RESP_OKAY);
                        rd_idx  = r_next_idx;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    // Read channel registers including the registered RAM read port.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rfixed_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rfixed_q  <= rfixed_d;
            if (rd_load)
                rdata_q <= rd_zero ? '0 : mem[rd_idx];
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi4_slave_ram.sv
// Bench for axi4_slave_ram: directed scenarios plus randomized bursts against a word-array model.
// Inputs driven and outputs sampled on the falling edge; all handshakes complete on the rising edge.
// Every wait on the DUT is bounded; an expired bound is reported as a failed comparison.
module tb_axi4_slave_ram;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    always #5 aclk = ~aclk;

    axi4_slave_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    logic [31:0] model [DEPTH];
    logic [31:0] wb_dat [256];
    logic [3:0]  wb_stb [256];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-word number of the first beat; anything at or beyond DEPTH is outside the RAM.
    function automatic bit dec_err(input logic [31:0] addr, input int len, input logic [1:0] burst);
        longint first_word;
        longint last_word;
        first_word = longint'(addr >> 2);
        last_word  = (burst == 2'b01) ? first_word + longint'(len) : first_word;
        return last_word >= longint'(DEPTH);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] addr, input int len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input bit bad_wlast);
        if (dec_err(addr, len, burst))
            return 2'b11;
        if (size != 3'd2 || burst >= 2'd2 || bad_wlast)
            return 2'b10;
        return 2'b00;
    endfunction

    task automatic fill_buf(input int len, input bit rnd_strb);
        for (int i = 0; i <= len; i++) begin
            wb_dat[i] = $urandom;
            wb_stb[i] = rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF;
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input bit bad_wlast, input int bhold);
        logic [1:0] er;
        int i;
        int g;
        int word;
        er = exp_resp(addr, len, size, burst, bad_wlast);
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
        awvalid = 1'b1;
        g = 0;
        while (!awready && g < 200) begin
            @(negedge aclk);
            g++;
        end
        if (!awready) chk_eq("aw_timeout", 64'(awready), 64'(1));
        @(negedge aclk);
        awvalid = 1'b0;
        chk_eq("wready_lat", 64'(wready), 64'(1));
        i = 0;
        g = 0;
        while (i <= len && g < 2000) begin
            wvalid = ($urandom_range(0, 3) != 0);
            wdata  = wb_dat[i];
            wstrb  = wb_stb[i];
            wlast  = bad_wlast ? 1'b0 : (i == len);
            if (wvalid && wready) i++;
            @(negedge aclk);
            g++;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        if (i <= len) chk_eq("w_timeout", 64'(i), 64'(len + 1));
        chk_eq("bvalid_lat", 64'(bvalid), 64'(1));
        for (int k = 0; k < bhold; k++) begin
            chk_eq("bvalid_hold", 64'(bvalid), 64'(1));
            chk_eq("awready_busy", 64'(awready), 64'(0));
            @(negedge aclk);
        end
        chk_eq("bid", 64'(bid), 64'(id));
        chk_eq("bresp", 64'(bresp), 64'(er));
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk_eq("bvalid_clr", 64'(bvalid), 64'(0));
        // Model: commit unless the burst is out of range or has bad size/burst type.
        if (!dec_err(addr, len, burst) && size == 3'd2 && burst < 2'd2) begin
            for (int b = 0; b <= len; b++) begin
                word = int'(addr >> 2) + ((burst == 2'b01) ? b : 0);
                for (int l = 0; l < 4; l++)
                    if (wb_stb[b][l]) model[word][l*8 +: 8] = wb_dat[b][l*8 +: 8];
            end
        end
    endtask

    // rmode: 0 rready always high, 1 alternating 0/1, 2 random.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int rmode);
        logic [1:0]  er;
        logic [31:0] exp_d;
        logic [31:0] s_dat;
        logic [1:0]  s_resp;
        logic        s_last;
        bit stalled;
        bit tog;
        int i;
        int g;
        er = exp_resp(addr, len, size, burst, 1'b0);
        @(negedge aclk);
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst;
        arvalid = 1'b1;
        g = 0;
        while (!arready && g < 200) begin
            @(negedge aclk);
            g++;
        end
        if (!arready) chk_eq("ar_timeout", 64'(arready), 64'(1));
        @(negedge aclk);
        arvalid = 1'b0;
        chk_eq("rvalid_lat", 64'(rvalid), 64'(1));
        i = 0; g = 0; stalled = 0; tog = 0;
        s_dat = '0; s_resp = '0; s_last = 1'b0;
        while (i <= len && g < 4000) begin
            case (rmode)
                0:       rready = 1'b1;
                1:       begin rready = tog; tog = !tog; end
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (!rvalid) begin
                chk_eq("rvalid_hold", 64'(rvalid), 64'(1));
                break;
            end
            if (stalled) begin
                chk_eq("stall_rdata", 64'(rdata), 64'(s_dat));
                chk_eq("stall_rresp", 64'(rresp), 64'(s_resp));
                chk_eq("stall_rlast", 64'(rlast), 64'(s_last));
            end
            if (rready) begin
                if (er != 2'b00)
                    exp_d = '0;
                else
                    exp_d = model[int'(addr >> 2) + ((burst == 2'b01) ? i : 0)];
                chk_eq("rdata", 64'(rdata), 64'(exp_d));
                chk_eq("rresp", 64'(rresp), 64'(er));
                chk_eq("rlast", 64'(rlast), 64'(i == len));
                chk_eq("rid", 64'(rid), 64'(id));
                i++;
                stalled = 0;
            end else begin
                stalled = 1;
                s_dat = rdata; s_resp = rresp; s_last = rlast;
            end
            @(negedge aclk);
            g++;
        end
        rready = 1'b0;
        if (i <= len) chk_eq("r_beats", 64'(i), 64'(len + 1));
        chk_eq("rvalid_end", 64'(rvalid), 64'(0));
    endtask

    initial begin
        logic [31:0] old_v;
        logic [31:0] new_v;
        logic [31:0] ra;
        int          rl;
        logic [1:0]  rb;
        logic [2:0]  rs;
        int          g;

        for (int k = 0; k < DEPTH; k++) model[k] = '0;

        // Reset values
        repeat (3) @(negedge aclk);
        chk_eq("rst_awready", 64'(awready), 64'(0));
        chk_eq("rst_arready", 64'(arready), 64'(0));
        chk_eq("rst_wready", 64'(wready), 64'(0));
        chk_eq("rst_bvalid", 64'(bvalid), 64'(0));
        chk_eq("rst_rvalid", 64'(rvalid), 64'(0));
        chk_eq("rst_rlast", 64'(rlast), 64'(0));
        chk_eq("rst_rdata", 64'(rdata), 64'(0));
        chk_eq("rst_ids", 64'({bid, rid, bresp, rresp}), 64'(0));
        areset_n = 1'b1;
        @(negedge aclk);
        chk_eq("rel_awready", 64'(awready), 64'(1));
        chk_eq("rel_arready", 64'(arready), 64'(1));

        // Give the whole RAM known contents
        for (int blk = 0; blk < DEPTH / 64; blk++) begin
            fill_buf(63, 1'b0);
            do_write(4'(blk), 32'(blk * 256), 63, 3'd2, 2'b01, 1'b0, 0);
        end

        // INCR write of 1..4 at 0x10 then read back
        for (int k = 0; k < 4; k++) begin wb_dat[k] = 32'(k + 1); wb_stb[k] = 4'hF; end
        do_write(4'd5, 32'h10, 3, 3'd2, 2'b01, 1'b0, 0);
        do_read(4'd9, 32'h10, 3, 3'd2, 2'b01, 0);

        // Partial strobe merge
        wb_dat[0] = 32'h11223344; wb_stb[0] = 4'hF;
        do_write(4'd1, 32'h20, 0, 3'd2, 2'b01, 1'b0, 0);
        wb_dat[0] = 32'hAABBCCDD; wb_stb[0] = 4'b0011;
        do_write(4'd2, 32'h20, 0, 3'd2, 2'b01, 1'b0, 0);
        do_read(4'd3, 32'h20, 0, 3'd2, 2'b01, 0);

        // Zero strobe writes nothing
        wb_dat[0] = 32'hDEADBEEF; wb_stb[0] = 4'h0;
        do_write(4'd4, 32'h24, 0, 3'd2, 2'b01, 1'b0, 0);
        do_read(4'd4, 32'h24, 0, 3'd2, 2'b01, 0);

        // Burst running past the top word, and an out-of-range read
        fill_buf(3, 1'b0);
        do_write(4'd6, 32'((DEPTH - 2) * 4), 3, 3'd2, 2'b01, 1'b0, 0);
        do_read(4'd6, 32'((DEPTH - 2) * 4), 1, 3'd2, 2'b01, 0);
        do_read(4'd7, 32'(DEPTH * 4), 1, 3'd2, 2'b01, 0);

        // Missing wlast commits data but reports SLVERR; bad size commits nothing
        fill_buf(2, 1'b0);
        do_write(4'd8, 32'h100, 2, 3'd2, 2'b01, 1'b1, 0);
        fill_buf(1, 1'b0);
        do_write(4'd8, 32'h200, 1, 3'd1, 2'b01, 1'b0, 0);
        do_read(4'd8, 32'h100, 2, 3'd2, 2'b01, 0);
        do_read(4'd8, 32'h200, 1, 3'd2, 2'b01, 0);

        // Held response and stalled read
        fill_buf(7, 1'b1);
        do_write(4'd10, 32'h300, 7, 3'd2, 2'b01, 1'b0, 5);
        do_read(4'd11, 32'h300, 7, 3'd2, 2'b01, 1);

        // Same-edge read and write of one word returns the old value
        @(negedge aclk);
        awid = 4'd12; awaddr = 32'h40; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
        awvalid = 1'b1;
        g = 0;
        while (!awready && g < 200) begin @(negedge aclk); g++; end
        if (!awready) chk_eq("cc_aw_timeout", 64'(awready), 64'(1));
        @(negedge aclk);
        awvalid = 1'b0;
        old_v = model[16];
        new_v = $urandom;
        chk_eq("cc_wready", 64'(wready), 64'(1));
        chk_eq("cc_arready", 64'(arready), 64'(1));
        wvalid = 1'b1; wdata = new_v; wstrb = 4'hF; wlast = 1'b1;
        arid = 4'd13; araddr = 32'h40; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        chk_eq("cc_rvalid", 64'(rvalid), 64'(1));
        chk_eq("cc_rdata_old", 64'(rdata), 64'(old_v));
        chk_eq("cc_rlast", 64'(rlast), 64'(1));
        chk_eq("cc_bvalid", 64'(bvalid), 64'(1));
        chk_eq("cc_bresp", 64'(bresp), 64'(0));
        rready = 1'b1; bready = 1'b1;
        @(negedge aclk);
        rready = 1'b0; bready = 1'b0;
        chk_eq("cc_rvalid_clr", 64'(rvalid), 64'(0));
        chk_eq("cc_bvalid_clr", 64'(bvalid), 64'(0));
        model[16] = new_v;
        do_read(4'd14, 32'h40, 0, 3'd2, 2'b01, 0);

        // Reset in the middle of a 4-beat read
        @(negedge aclk);
        arid = 4'd2; araddr = 32'h80; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        g = 0;
        while (!arready && g < 200) begin @(negedge aclk); g++; end
        if (!arready) chk_eq("rr_ar_timeout", 64'(arready), 64'(1));
        @(negedge aclk);
        arvalid = 1'b0;
        rready = 1'b1;
        chk_eq("rr_beat0", 64'(rdata), 64'(model[32]));
        @(negedge aclk);
        chk_eq("rr_beat1", 64'(rdata), 64'(model[33]));
        @(negedge aclk);
        #1 areset_n = 1'b0;
        #1;
        chk_eq("rr_rvalid", 64'(rvalid), 64'(0));
        chk_eq("rr_rlast", 64'(rlast), 64'(0));
        chk_eq("rr_arready", 64'(arready), 64'(0));
        chk_eq("rr_rdata", 64'(rdata), 64'(0));
        rready = 1'b0;
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
        chk_eq("rr_arready_rel", 64'(arready), 64'(1));
        chk_eq("rr_awready_rel", 64'(awready), 64'(1));
        chk_eq("rr_rvalid_rel", 64'(rvalid), 64'(0));
        do_read(4'd3, 32'h80, 3, 3'd2, 2'b01, 2);

        // Randomized bursts
        for (int it = 0; it < 40; it++) begin
            ra = 32'($urandom_range(0, DEPTH - 1)) << 2;
            if ($urandom_range(0, 9) == 0) ra = ra | (32'h1000 << $urandom_range(0, 19));
            rl = $urandom_range(0, 15);
            case ($urandom_range(0, 9))
                0, 1:    rb = 2'b00;
                9:       rb = 2'($urandom_range(2, 3));
                default: rb = 2'b01;
            endcase
            rs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            if ($urandom_range(0, 1) == 0) begin
                fill_buf(rl, 1'b1);
                do_write(4'($urandom), ra, rl, rs, rb, ($urandom_range(0, 9) == 0),
                         $urandom_range(0, 2));
            end else begin
                do_read(4'($urandom), ra, rl, rs, rb, 2);
            end
        end
        // Sweep the whole RAM once more against the model
        for (int blk = 0; blk < DEPTH / 64; blk++)
            do_read(4'(blk), 32'(blk * 256), 63, 3'd2, 2'b01, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_slave_ram.md
AXI4_SLAVE_RAM -- requirements
Module: axi4_slave_ram

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bus width in bits (32/64/128).
REQ-002 SHALL have parameter DEPTH, default 256, memory depth in WIDTH-bit words (power of two).
REQ-003 SHALL have port aclk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port areset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port awid  input  4  write ID tag.
REQ-006 SHALL have port awaddr  input  32  byte address of first write beat.
REQ-007 SHALL have port awlen  input  8  write beats minus one.
REQ-008 SHALL have port awsize  input  3  bytes per beat, 2^n.
REQ-009 SHALL have port awburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-010 SHALL have port awvalid  input  1  write address valid.
REQ-011 SHALL have port awready  output  1  write address accepted.
REQ-012 SHALL have port wdata  input  WIDTH  write data.
REQ-013 SHALL have port wstrb  input  WIDTH/8  byte-lane enables.
REQ-014 SHALL have port wlast  input  1  last write beat marker.
REQ-015 SHALL have port wvalid  input  1  write data valid.
REQ-016 SHALL have port wready  output  1  write data accepted.
REQ-017 SHALL have port bid  output  4  response ID, equals captured awid.
REQ-018 SHALL have port bresp  output  2  00 OKAY, 10 SLVERR, 11 DECERR.
REQ-019 SHALL have port bvalid  output  1  write response valid.
REQ-020 SHALL have port bready  input  1  master accepts response.
REQ-021 SHALL have port arid  input  4  read ID tag.
REQ-022 SHALL have port araddr  input  32  byte address of first read beat.
REQ-023 SHALL have port arlen  input  8  read beats minus one.
REQ-024 SHALL have port arsize  input  3  bytes per beat, 2^n.
REQ-025 SHALL have port arburst  input  2  burst type, encoding as awburst.
REQ-026 SHALL have port arvalid  input  1  read address valid.
REQ-027 SHALL have port arready  output  1  read address accepted.
REQ-028 SHALL have port rid  output  4  read ID, equals captured arid.
REQ-029 SHALL have port rdata  output  WIDTH  read data.
REQ-030 SHALL have port rresp  output  2  per-beat status, encoding as bresp.
REQ-031 SHALL have port rlast  output  1  last read beat.
REQ-032 SHALL have port rvalid  output  1  read data valid.
REQ-033 SHALL have port rready  input  1  master accepts read data.

Function
REQ-034 Write FSM SHALL be W_IDLE (awready=1) -> W_DATA on awvalid&&awready (capture id/addr/len/burst/error); W_DATA (wready=1) -> W_RESP after beat awlen accepted, counting beats and ignoring wlast; W_RESP (bvalid=1) -> W_IDLE on bready; bvalid held stable until accepted.
REQ-035 Read FSM SHALL be R_IDLE (arready=1) -> R_DATA on arvalid&&arready; R_DATA (rvalid=1) advances on rvalid&&rready; rlast=1 on beat arlen only; -> R_IDLE after last beat accepted; rdata/rresp/rlast stable while rvalid&&!rready.
REQ-036 Latency SHALL be: AW handshake at cycle N -> wready at N+1; last W beat at M -> bvalid at M+1; AR handshake at N -> first rvalid at N+1; one beat per cycle when rready held high.
REQ-037 Word index SHALL be addr[log2(WIDTH/8) +: log2(DEPTH)]; INCR adds 1 per beat; FIXED holds; no wrap-around of the index.
REQ-038 Accepted write beats SHALL update only byte lanes with wstrb bit set; wstrb=0 writes nothing.
REQ-039 DECERR SHALL apply when start word + len (INCR) or start word (FIXED) >= DEPTH, or any address bits above memory range are nonzero.
REQ-040 SLVERR SHALL apply for awsize/arsize != log2(WIDTH/8), burst WRAP or 11, or wlast mismatching the final counted beat; precedence is DECERR > SLVERR > OKAY.
REQ-041 Erroneous write bursts SHALL accept all beats and commit none, except a wlast mismatch, which commits beats and reports SLVERR; erroneous read bursts SHALL return all arlen+1 beats with rdata=0 and the error rresp.
REQ-042 Read and write channels SHALL operate concurrently; a same-cycle read and write to one word SHALL return the pre-write data.

Reset
REQ-043 While areset_n=0: awready, wready, bvalid, arready, rvalid, rlast=0; bresp, rresp, bid, rid, rdata=0; FSMs in IDLE; awready/arready=1 from the first edge after release; memory contents not reset; reset mid-burst abandons the burst without response.

Verification
REQ-044 INCR write awaddr=0x10, awlen=3, wstrb=F, data 1..4 -> bresp=00, bid=awid; INCR read same address, len=3 -> rdata 1,2,3,4, rlast on 4th beat only.
REQ-045 Write wstrb=4'b0011 data 0xAABBCCDD over 0x11223344 -> read returns 0x1122CCDD.
REQ-046 awaddr=(DEPTH-2)*4, awlen=3, INCR -> bresp=11, memory unchanged; araddr out of range, len=1 -> two beats rdata=0, rresp=11.
REQ-047 rready toggled 1/0 during 8-beat read -> no beat lost or duplicated, outputs stable while stalled; bready held 0 for 5 cycles -> bvalid held, awready stays 0.
REQ-048 Reset asserted during read beat 2 of 4 -> rvalid=0 immediately; after release arready=1 and a new burst completes correctly.
